// File: rtl/pad_mux_pkg.sv
// pad_mux_pkg: shared state, attribute types and widths for pad_mux_ctrl (PAD_MUX_LOCK_EN adds a lock bit to cfg_attr)
package pad_mux_pkg;

    typedef enum logic [1:0] {IDLE, DRAIN, APPLY, REJECT} pad_mux_state_e;

    typedef struct packed {
        logic cs;
        logic sl;
        logic ie;
        logic pu;
        logic pd;
    } pad_attr_t;

    localparam pad_attr_t PAD_ATTR_RST = '{cs: 1'b0, sl: 1'b0, ie: 1'b1, pu: 1'b0, pd: 1'b0};

`ifdef PAD_MUX_LOCK_EN
    localparam int ATTR_W = 6;
`else
    localparam int ATTR_W = 5;
`endif

endpackage

// File: rtl/pad_mux_slice.sv
// pad_mux_slice: one pad's function select, electrical attributes, output/OE mux and input fan-out
module pad_mux_slice
    import pad_mux_pkg::*;
#(
    parameter int NUM_FUNCS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         drain,
    input  logic                         we,
    input  logic [$clog2(NUM_FUNCS)-1:0] func,
    input  logic [4:0]                   attr,
    input  logic [NUM_FUNCS-1:0]         fn_out,
    input  logic [NUM_FUNCS-1:0]         fn_oe,
    input  logic                         pad_in,
    output logic                         pad_out,
    output logic                         pad_oe,
    output logic [4:0]                   attr_q,
    output logic [NUM_FUNCS-1:0]         fn_in
);

    localparam int FW = $clog2(NUM_FUNCS);

    logic [FW-1:0] sel;
    pad_attr_t     cfg;

    // Pad configuration, loaded only by the write strobe from the sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= '0;
            cfg <= PAD_ATTR_RST;
        end else if (we) begin
            sel <= func;
            cfg <= pad_attr_t'(attr);
        end
    end

    assign pad_out = fn_out[sel];
    assign pad_oe  = fn_oe[sel] & ~drain;
    assign attr_q  = cfg;

    // Only the selected function sees the pad, and only while the input buffer is enabled
    always_comb begin
        fn_in = '0;
        for (int f = 0; f < NUM_FUNCS; f++)
            fn_in[f] = pad_in & cfg.ie & (sel == FW'(f));
    end

endmodule

// File: rtl/pad_mux_ctrl.sv
// pad_mux_ctrl: sequenced pad-function mux; OE is drained for GUARD_CYCLES before a config change (optional PAD_MUX_LOCK_EN)
module pad_mux_ctrl
    import pad_mux_pkg::*;
#(
    parameter int NUM_PADS     = 40,
    parameter int NUM_FUNCS    = 4,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [$clog2(NUM_PADS)-1:0]    cfg_pad,
    input  logic [$clog2(NUM_FUNCS)-1:0]   cfg_func,
    input  logic [ATTR_W-1:0]              cfg_attr,
    output logic                           cfg_done,
    output logic                           cfg_err,
    input  logic [NUM_FUNCS*NUM_PADS-1:0]  fn_out,
    input  logic [NUM_FUNCS*NUM_PADS-1:0]  fn_oe,
    output logic [NUM_FUNCS*NUM_PADS-1:0]  fn_in,
    input  logic [NUM_PADS-1:0]            pad_in,
    output logic [NUM_PADS-1:0]            pad_out,
    output logic [NUM_PADS-1:0]            pad_oe,
    output logic [NUM_PADS-1:0]            pad_cs,
    output logic [NUM_PADS-1:0]            pad_sl,
    output logic [NUM_PADS-1:0]            pad_ie,
    output logic [NUM_PADS-1:0]            pad_pu,
    output logic [NUM_PADS-1:0]            pad_pd
);

    localparam int PW = $clog2(NUM_PADS);
    localparam int FW = $clog2(NUM_FUNCS);
    localparam int CW = GUARD_CYCLES > 1 ? $clog2(GUARD_CYCLES) : 1;

    pad_mux_state_e state;
    logic [CW-1:0]  cnt;
    logic [PW-1:0]  r_pad;
    logic [FW-1:0]  r_func;
    pad_attr_t      r_attr;
    logic           rej;
    logic           busy;

    assign cfg_ready = state == IDLE;
    assign busy      = state == DRAIN || state == APPLY;

`ifdef PAD_MUX_LOCK_EN
    logic [NUM_PADS-1:0] lock;
    logic                r_lock;

    // Lock bit travels with the request and sticks on its pad once applied; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock   <= '0;
            r_lock <= 1'b0;
        end else begin
            if (cfg_valid && cfg_ready) r_lock <= cfg_attr[ATTR_W-1];
            if (state == APPLY && r_lock) lock[r_pad] <= 1'b1;
        end
    end

    assign rej = 32'(cfg_pad) >= NUM_PADS || lock[cfg_pad];
`else
    assign rej = 32'(cfg_pad) >= NUM_PADS;
`endif

    // Request sequencer: capture, drain the target pad's OE, then apply or reject with a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            r_pad    <= '0;
            r_func   <= '0;
            r_attr   <= PAD_ATTR_RST;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                IDLE: if (cfg_valid) begin
                    r_pad  <= cfg_pad;
                    r_func <= cfg_func;
                    r_attr <= pad_attr_t'(cfg_attr[4:0]);
                    cnt    <= CW'(GUARD_CYCLES > 0 ? GUARD_CYCLES - 1 : 0);
                    if (rej) begin
                        state    <= REJECT;
                        cfg_done <= 1'b1;
                        cfg_err  <= 1'b1;
                    end else if (GUARD_CYCLES == 0) begin
                        state    <= APPLY;
                        cfg_done <= 1'b1;
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: if (cnt == '0) begin
                    state    <= APPLY;
                    cfg_done <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        logic [NUM_FUNCS-1:0] fo, fe, fi;
        logic [4:0]           aq;
        for (genvar f = 0; f < NUM_FUNCS; f++) begin : g_fn
            assign fo[f] = fn_out[f*NUM_PADS+i];
            assign fe[f] = fn_oe[f*NUM_PADS+i];
            assign fn_in[f*NUM_PADS+i] = fi[f];
        end
        pad_mux_slice #(.NUM_FUNCS(NUM_FUNCS)) u_slice (
            .clk    (clk),
            .rst_n  (rst_n),
            .drain  (busy && r_pad == PW'(i)),
            .we     (state == APPLY && r_pad == PW'(i)),
            .func   (r_func),
            .attr   (r_attr),
            .fn_out (fo),
            .fn_oe  (fe),
            .pad_in (pad_in[i]),
            .pad_out(pad_out[i]),
            .pad_oe (pad_oe[i]),
            .attr_q (aq),
            .fn_in  (fi)
        );
        assign {pad_cs[i], pad_sl[i], pad_ie[i], pad_pu[i], pad_pd[i]} = aq;
    end

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// tb_pad_mux_ctrl: randomized bench for pad_mux_ctrl against a transaction-level model
module tb_pad_mux_ctrl;
    import pad_mux_pkg::*;

    localparam int NP = 40;
    localparam int NF = 4;
    localparam int G  = 4;
    localparam int W  = NP * NF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [5:0]        cfg_pad = '0;
    logic [1:0]        cfg_func = '0;
    logic [ATTR_W-1:0] cfg_attr = '0;
    logic              cfg_done, cfg_err;
    logic [W-1:0]      fn_out = '0, fn_oe = '0, fn_in;
    logic [NP-1:0]     pad_in = '0;
    logic [NP-1:0]     pad_out, pad_oe, pad_cs, pad_sl, pad_ie, pad_pu, pad_pd;

    pad_mux_ctrl #(.NUM_PADS(NP), .NUM_FUNCS(NF), .GUARD_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pad(cfg_pad), .cfg_func(cfg_func), .cfg_attr(cfg_attr),
        .cfg_done(cfg_done), .cfg_err(cfg_err), .fn_out(fn_out), .fn_oe(fn_oe),
        .fn_in(fn_in), .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe),
        .pad_cs(pad_cs), .pad_sl(pad_sl), .pad_ie(pad_ie), .pad_pu(pad_pu), .pad_pd(pad_pd)
    );

    always #5 clk = ~clk;

    // Reference model: per-pad config table plus one pending transaction timed by edge arithmetic
    int                m_sel [NP];
    logic [4:0]        m_attr[NP];
    bit                m_lock[NP];
    bit                pend, p_rej;
    int                p_pad, p_func, cyc, acc;
    logic [ATTR_W-1:0] p_attr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) begin
                m_sel[i]  <= 0;
                m_attr[i] <= 5'b00100;
                m_lock[i] <= 1'b0;
            end
            pend <= 1'b0;
            cyc  <= 0;
        end else begin
            cyc <= cyc + 1;
            if (!pend) begin
                if (cfg_valid) begin
                    pend   <= 1'b1;
                    acc    <= cyc + 1;
                    p_pad  <= int'(cfg_pad);
                    p_func <= int'(cfg_func);
                    p_attr <= cfg_attr;
                    p_rej  <= (int'(cfg_pad) >= NP) ? 1'b1 : m_lock[cfg_pad];
                end
            end else if (cyc + 1 == acc + (p_rej ? 1 : G + 1)) begin
                pend <= 1'b0;
                if (!p_rej) begin
                    m_sel[p_pad]  <= p_func;
                    m_attr[p_pad] <= p_attr[4:0];
                    if (ATTR_W > 5 && p_attr[ATTR_W-1]) m_lock[p_pad] <= 1'b1;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit force_oe = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NP-1:0] e_out, e_oe, e_cs, e_sl, e_ie, e_pu, e_pd;
        logic [W-1:0]  e_in;
        bit            e_done;
        e_in = '0;
        for (int i = 0; i < NP; i++) begin
            int s;
            s = m_sel[i];
            e_out[i] = fn_out[s*NP+i];
            e_oe[i]  = fn_oe[s*NP+i] && !(pend && !p_rej && p_pad == i);
            {e_cs[i], e_sl[i], e_ie[i], e_pu[i], e_pd[i]} = m_attr[i];
            e_in[s*NP+i] = pad_in[i] && m_attr[i][2];
        end
        e_done = pend && cyc == acc + (p_rej ? 0 : G);
        chk("cfg_ready", cfg_ready, !pend);
        chk("cfg_done", cfg_done, e_done);
        chk("cfg_err", cfg_err, e_done && p_rej);
        chk("pad_out", pad_out, e_out);
        chk("pad_oe", pad_oe, e_oe);
        chk("pad_cs", pad_cs, e_cs);
        chk("pad_sl", pad_sl, e_sl);
        chk("pad_ie", pad_ie, e_ie);
        chk("pad_pu", pad_pu, e_pu);
        chk("pad_pd", pad_pd, e_pd);
        chk("fn_in", fn_in, e_in);
    endtask

    task automatic step(input bit v, input int pad, input int func, input int at);
        @(negedge clk);
        cfg_valid = v;
        cfg_pad   = 6'(pad);
        cfg_func  = 2'(func);
        cfg_attr  = ATTR_W'(at);
        fn_out    = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        fn_oe     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        pad_in    = {$urandom(), $urandom()};
        if (force_oe) fn_oe[3] = 1'b1;
        #1 compare_all();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (pend && n < 20) begin
            step(0, 0, 0, 0);
            n++;
        end
        chk("idle_timeout", pend, 1'b0);
    endtask

    task automatic rst_pulse();
        #2 rst_n = 1'b0;
        #1 compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1 compare_all();
        @(negedge clk);
        #1 compare_all();
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        // select function 2 on pad 3 while function 0 is driving it
        force_oe = 1'b1;
        step(1, 3, 2, 'b00110);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0);
        force_oe = 1'b0;
        // out-of-range pad index is rejected
        step(1, 45, 1, 'b11111);
        wait_idle();
        step(0, 0, 0, 0);
        // back-to-back requests with valid held high
        for (int k = 0; k < 14; k++) step(1, 5 + (k & 1), k & 3, int'($urandom_range(0, 31)));
        step(0, 0, 0, 0);
        wait_idle();
        // reset while pad 7 is draining
        step(1, 7, 3, 'b10001);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst_pulse();
        step(0, 0, 0, 0);
        // lock pad 1, then retry it and write pad 2
        step(1, 1, 1, 'b100100);
        wait_idle();
        step(1, 1, 2, 'b000110);
        wait_idle();
        step(1, 2, 3, 'b001100);
        wait_idle();
        step(0, 0, 0, 0);
        // random traffic
        for (int k = 0; k < 3000; k++) begin
            int pad;
            pad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 63)) : int'($urandom_range(0, 39));
            step($urandom_range(0, 9) < 4, pad, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 31)) | (($urandom_range(0, 15) == 0) ? 32 : 0));
            if ($urandom_range(0, 499) == 0) rst_pulse();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pad_mux_ctrl.md
Name: pad_mux_ctrl

Overview:
- Sequenced pad-function multiplexer between chip_core peripherals and the bidirectional pad ring.
- Each bidir pad is shared by NUM_FUNCS requesters (function 0 = GPIO).
- Per-pad select and electrical settings (CS/SL/IE/PU/PD) are programmed through a valid/ready config port.
- A function change forces the pad's OE low for GUARD_CYCLES before the switch, so the pad never glitches between two drivers.

Parameters:
- NUM_PADS, 40, number of bidir pads controlled.
- NUM_FUNCS, 4, requesters per pad; must be a power of two, ≥2.
- GUARD_CYCLES, 4, OE-forced-low cycles before applying a new config; 0 allowed.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  async active-low reset.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config port can accept.
- cfg_pad  in  $clog2(NUM_PADS)  target pad index.
- cfg_func  in  $clog2(NUM_FUNCS)  function select.
- cfg_attr  in  5  {cs, sl, ie, pu, pd}.
- cfg_done  out  1  one-cycle completion pulse.
- cfg_err  out  1  qualifies cfg_done: request rejected.
- fn_out  in  NUM_FUNCS*NUM_PADS  function drive data; bit f*NUM_PADS+i is function f on pad i.
- fn_oe  in  NUM_FUNCS*NUM_PADS  function output enables, same packing.
- fn_in  out  NUM_FUNCS*NUM_PADS  pad input routed to the selected function.
- pad_in  in  NUM_PADS  from the pad Y pins.
- pad_out, pad_oe, pad_cs, pad_sl, pad_ie, pad_pu, pad_pd  out  NUM_PADS each  to the pad A/OE/CS/SL/IE/PU/PD pins.

Behaviour:
- Clock and reset: clk; rst_n is asynchronous, active-low. Reset is asynchronous assertion only; synchronous deassertion is provided upstream.
- Reset values: all pads func=0, cs=0, sl=0, ie=1, pu=0, pd=0. FSM=IDLE, cfg_ready=1, cfg_done=0, cfg_err=0.
- Datapath (combinational from registered config):
  - pad_out[i] = fn_out[sel_i*NUM_PADS+i].
  - pad_oe[i] = fn_oe[sel_i*NUM_PADS+i] & ~drain_mask[i].
  - pad_cs/sl/ie/pu/pd[i] come directly from config registers.
  - fn_in[f*NUM_PADS+i] = pad_in[i] & (sel_i==f) & ie_i. Unselected functions read 0.
- Handshake: cfg_ready=1 only in IDLE. A request is accepted on a rising edge with cfg_valid & cfg_ready. Inputs are captured at acceptance; cfg_* may change afterwards.
- FSM states: IDLE, DRAIN, APPLY, REJECT.
  - IDLE -> REJECT if accepted and cfg_pad ≥ NUM_PADS.
  - IDLE -> DRAIN if accepted, GUARD_CYCLES>0 and index valid.
  - IDLE -> APPLY if accepted, GUARD_CYCLES=0 and index valid.
  - DRAIN: drain_mask[pad]=1 (that pad's OE forced 0). Counter loads GUARD_CYCLES-1 and decrements; -> APPLY when it reaches 0, after exactly GUARD_CYCLES cycles in DRAIN.
  - APPLY: drain_mask stays 1; cfg_done=1, cfg_err=0. Config registers are written at the end of the cycle. -> IDLE.
  - REJECT: cfg_done=1, cfg_err=1, no register change. -> IDLE.
- Latency: accept at edge k. The new config drives the pads from cycle k+GUARD_CYCLES+2. The next acceptance is possible at that same edge.
- No change-detection: a rewrite of an identical config still drains.
- Other pads are never affected during a transaction.
- Reset mid-transaction: immediate return to IDLE with reset config; drain_mask clears and the pending write is lost.
- cfg_done and cfg_err are registered outputs.

Optional Feature:
- Macro: PAD_MUX_LOCK_EN.
- Defined:
  - cfg_attr widens to 6 bits; bit 5 = lock.
  - Applying a config with lock=1 sets lock_i.
  - Any later request to a locked pad goes IDLE->REJECT (cfg_err=1).
  - Locks clear only on rst_n.
- Undefined: cfg_attr is 5 bits, no lock state, no lock-based rejects.

Decomposition:
- Package pad_mux_pkg holds:
  - state enum pad_mux_state_e {IDLE, DRAIN, APPLY, REJECT};
  - typedef pad_attr_t, a packed struct {cs, sl, ie, pu, pd};
  - reset constant PAD_ATTR_RST = '{cs:0, sl:0, ie:1, pu:0, pd:0}.
- Sub-module pad_mux_slice: one per pad. It holds that pad's config registers, the per-pad output/OE select and fn_in gating, and takes drain and write strobes from the top FSM.

Test Plan:
- Reset -> all pad_oe=0 with fn_oe=0, pad_ie all 1, cfg_ready=1. With fn_oe[0*40+3]=1 and fn_out[3]=1, pad_out[3]=1 and pad_oe[3]=1.
- Write pad 3, func 2, attr 5'b00110 at edge k with fn_oe of func 0 on pad 3 high:
  - pad_oe[3]=0 for cycles k+1..k+5;
  - cfg_done=1 at k+5;
  - from k+6, pad_oe[3] follows fn_oe[2*40+3], pu[3]=1, fn_in[0*40+3]=0, fn_in[2*40+3]=pad_in[3];
  - pads 0-2 and 4-39 are unchanged throughout.
- cfg_pad=45 -> cfg_done=cfg_err=1 one cycle after accept, no output change, cfg_ready back the following cycle.
- Back-to-back writes with cfg_valid held high: second accepted exactly at edge k+6; cfg_ready=0 during k+1..k+5.
- rst_n pulsed low during DRAIN of pad 7 -> immediate reset config, no cfg_done, pad 7 func=0.
- PAD_MUX_LOCK_EN: write pad 1 with lock=1, then write pad 1 again -> second returns cfg_err=1, config retained; pad 2 writes still succeed.
